// File: rtl/uart_pkg.sv
// Shared types and helpers for the streaming UART receiver.
// Optional parity support in the receiver is selected with UART_RX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    // Clocks per oversample tick, rounded to nearest, never below 1.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        int d;
        d = (clk_hz + (baud * os) / 2) / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

    // Divisor for the default 50 MHz / 115200 baud / x16 configuration.
    localparam int DIV = calc_div(50000000, 115200, 16);

endpackage

// File: rtl/uart_rx_stream_if.sv
// Valid/ready word stream carrying received UART payloads to the consumer.
interface uart_rx_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead single-clock FIFO with occupancy count. A push into a full FIFO
// succeeds only when a pop happens in the same cycle; otherwise it is dropped
// and reported on drop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop_ready,
    output logic [WIDTH-1:0]       head,
    output logic                   not_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign not_empty = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign do_pop    = not_empty & pop_ready;
    assign do_push   = push & (~full | do_pop);
    assign drop      = push & full & ~do_pop;
    assign head      = mem[rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_stream.sv
// Oversampling UART receiver feeding a show-ahead FIFO and a valid/ready stream.
// Holds the rx synchronizer, tick generator, shift register, receive FSM and
// error pulses. Define UART_RX_PARITY_EN to expect a parity bit after the data.
//
//   state  | meaning
//   IDLE   | line idle, waiting for a synchronized falling edge
//   START  | qualifying the start bit at its centre
//   DATA   | sampling payload bits LSB first
//   PARITY | sampling the parity bit (parity builds only)
//   STOP   | sampling stop bit(s); all high pushes the word
//   BREAK  | framing error seen, waiting for the line to return high
module uart_rx_stream
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx,
    input  logic                        parity_odd,
    uart_rx_stream_if.master            m,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        overrun,
    output logic                        parity_err
);
    localparam int DIV_CFG = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int DW      = (DIV_CFG > 1) ? $clog2(DIV_CFG) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS + 1);
    localparam logic [DW-1:0] DIV_M1 = DW'(DIV_CFG - 1);

    rx_state_e            state_q;
    rx_state_e            state_nxt;
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_prev;
    logic                 fall;
    logic [DW-1:0]        div_cnt;
    logic                 tick;
    logic [SW-1:0]        samp_cnt;
    logic                 sample_now;
    logic [BW-1:0]        bit_cnt;
    logic                 last_data;
    logic                 last_stop;
    logic [DATA_BITS-1:0] shift_q;
    logic                 shift_en;
    logic                 push_set;
    logic                 ferr_set;
    logic                 push_req;

    assign fall      = rx_prev & ~rx_s2;
    assign tick      = (div_cnt == '0);
    assign last_data = (bit_cnt == BW'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));
    assign sample_now = tick && ((state_q == START) ? (samp_cnt == SW'(OVERSAMPLE/2 - 1))
                                                    : (samp_cnt == SW'(OVERSAMPLE - 1)));

    // Two-flop synchronizer plus one history stage for edge detection; idle high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Free-running tick down-counter, re-phased to the detected start edge.
    always_ff @(posedge clk) begin
        if (!rst_n || (state_q == IDLE && fall) || tick) div_cnt <= DIV_M1;
        else                                             div_cnt <= div_cnt - 1'b1;
    end

    // Oversample counter: held at zero while idle, cleared at each sample point.
    always_ff @(posedge clk) begin
        if (!rst_n || state_q == IDLE) samp_cnt <= '0;
        else if (tick)                 samp_cnt <= sample_now ? '0 : samp_cnt + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:   if (fall) state_nxt = START;
            START:  if (sample_now) state_nxt = rx_s2 ? IDLE : DATA;
            DATA: begin
                if (sample_now && last_data) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
            PARITY: if (sample_now) state_nxt = STOP;
            STOP: begin
                if (sample_now) begin
                    if (!rx_s2)         state_nxt = BREAK;
                    else if (last_stop) state_nxt = IDLE;
                end
            end
            BREAK:  if (rx_s2) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: datapath strobes at the sample points.
    always_comb begin
        shift_en = 1'b0;
        push_set = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            DATA: shift_en = sample_now;
            STOP: begin
                if (sample_now) begin
                    if (!rx_s2)         ferr_set = 1'b1;
                    else if (last_stop) push_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Shift register, bit counter and one-cycle push / framing pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_cnt   <= '0;
            push_req  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push_req  <= push_set;
            frame_err <= ferr_set;
            if (state_q != state_nxt)                           bit_cnt <= '0;
            else if (shift_en || (state_q == STOP && sample_now)) bit_cnt <= bit_cnt + 1'b1;
            if (shift_en) shift_q <= {rx_s2, shift_q[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;

    // Parity check latched at the parity sample, reported alongside the push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state_q == PARITY && sample_now) par_bad <= ((^shift_q) ^ rx_s2) != parity_odd;
            parity_err <= push_set & par_bad;
        end
    end
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign parity_err        = 1'b0;
`endif

    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_not_empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (shift_q),
        .pop_ready (m.ready),
        .head      (fifo_head),
        .not_empty (fifo_not_empty),
        .count     (fifo_count),
        .drop      (overrun)
    );

    assign m.data  = fifo_head;
    assign m.valid = fifo_not_empty;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Self-checking bench for uart_rx_stream; a negedge monitor pops expected
// words from a scoreboard queue on every accepted transfer.
module tb_uart_rx_stream;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_OFS = 16;
`else
    localparam int PAR_OFS = 0;
`endif
    // Frame start (rx falls just after posedge n0) -> push cycle / first m_valid cycle.
    localparam int PUSH_OFS = 155 + PAR_OFS;
    localparam int RISE_OFS = 156 + PAR_OFS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       parity_odd = 1'b0;
    logic [4:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    uart_rx_stream_if #(.WIDTH(8)) m_if ();

    uart_rx_stream #(
        .CLK_FREQ   (16000000),
        .BAUD       (1000000),
        .OVERSAMPLE (16),
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .FIFO_DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .parity_odd (parity_odd),
        .m          (m_if),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int frame_start = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_word;
    int valid_rises, valid_cycles, ferr_cnt, ovr_cnt, perr_cnt;
    int last_rise_cyc, last_perr_cyc;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_if.valid && !prev_valid) begin
            valid_rises++;
            last_rise_cyc = cyc;
        end
        if (m_if.valid) valid_cycles++;
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (parity_err) begin
            perr_cnt++;
            last_perr_cyc = cyc;
        end
        prev_valid = m_if.valid;
        if (m_if.valid && m_if.ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_pop: got %02h, expected no word", m_if.data);
            end else begin
                exp_word = sb.pop_front();
                if (m_if.data !== exp_word) begin
                    failures++;
                    $display("FAIL sb_data: got %02h, expected %02h", m_if.data, exp_word);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        valid_rises = 0; valid_cycles = 0;
        ferr_cnt = 0; ovr_cnt = 0; perr_cnt = 0;
        last_rise_cyc = -1; last_perr_cyc = -1;
    endtask

    // One 8-bit frame, 16 clk per bit; caller is aligned just after a posedge.
    task automatic send_frame(input logic [7:0] d, input logic stop_lvl);
        frame_start = cyc;
        rx = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            step(16);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ parity_odd;
        step(16);
`endif
        rx = stop_lvl;
        step(16);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(4);
        checks++; if (m_if.valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b, expected 0", m_if.valid); end
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL reset_count: got %0d, expected 0", fifo_count); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b, expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr: got %b, expected 0", overrun); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_perr: got %b, expected 0", parity_err); end
        rst_n = 1'b1;
        step(4);
    endtask

    task automatic test_single();
        clear_counters();
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        step(20);
        checks++; if (last_rise_cyc !== frame_start + RISE_OFS) begin failures++; $display("FAIL single_latency: got cycle %0d, expected %0d", last_rise_cyc, frame_start + RISE_OFS); end
        checks++; if (valid_cycles !== 1) begin failures++; $display("FAIL single_valid_len: got %0d, expected 1", valid_cycles); end
        checks++; if (ferr_cnt !== 0) begin failures++; $display("FAIL single_ferr: got %0d, expected 0", ferr_cnt); end
        checks++; if (ovr_cnt !== 0) begin failures++; $display("FAIL single_ovr: got %0d, expected 0", ovr_cnt); end
        checks++; if (perr_cnt !== 0) begin failures++; $display("FAIL single_perr: got %0d, expected 0", perr_cnt); end
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL single_sb: got %0d pending, expected 0", sb.size()); end
    endtask

    task automatic test_frame_error();
        clear_counters();
        send_frame(8'h3C, 1'b0);
        step(20);
        checks++; if (ferr_cnt !== 1) begin failures++; $display("FAIL ferr_pulses: got %0d, expected 1", ferr_cnt); end
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL ferr_count: got %0d, expected 0", fifo_count); end
        checks++; if (valid_rises !== 0) begin failures++; $display("FAIL ferr_valid: got %0d rises, expected 0", valid_rises); end
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        step(20);
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL ferr_next_sb: got %0d pending, expected 0", sb.size()); end
        checks++; if (ferr_cnt !== 1) begin failures++; $display("FAIL ferr_next_pulses: got %0d, expected 1", ferr_cnt); end
    endtask

    task automatic test_overrun();
        m_if.ready = 1'b0;
        clear_counters();
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        step(10);
        checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL ovr_count: got %0d, expected 16", fifo_count); end
        checks++; if (ovr_cnt !== 1) begin failures++; $display("FAIL ovr_pulses: got %0d, expected 1", ovr_cnt); end
        m_if.ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) step(1);
        step(2);
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL ovr_drain: got %0d pending, expected 0", sb.size()); end
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL ovr_drain_count: got %0d, expected 0", fifo_count); end
    endtask

    task automatic test_full_push_pop();
        m_if.ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sb.push_back(8'(8'h20 + i));
            send_frame(8'(8'h20 + i), 1'b1);
        end
        step(5);
        checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL full_fill: got %0d, expected 16", fifo_count); end
        clear_counters();
        sb.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            begin
                step(PUSH_OFS);
                m_if.ready = 1'b1;
                step(1);
                m_if.ready = 1'b0;
            end
        join
        step(10);
        checks++; if (ovr_cnt !== 0) begin failures++; $display("FAIL full_ovr: got %0d, expected 0", ovr_cnt); end
        checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL full_count: got %0d, expected 16", fifo_count); end
        checks++; if (sb.size() !== 16) begin failures++; $display("FAIL full_popped: got %0d pending, expected 16", sb.size()); end
        m_if.ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) step(1);
        step(2);
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL full_drain: got %0d pending, expected 0", sb.size()); end
    endtask

    task automatic test_glitch_and_reset();
        clear_counters();
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(40);
        checks++; if (valid_rises !== 0) begin failures++; $display("FAIL glitch_valid: got %0d rises, expected 0", valid_rises); end
        checks++; if (ferr_cnt !== 0) begin failures++; $display("FAIL glitch_ferr: got %0d, expected 0", ferr_cnt); end
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        step(20);
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL glitch_next_sb: got %0d pending, expected 0", sb.size()); end
        m_if.ready = 1'b0;
        send_frame(8'h42, 1'b1);
        step(5);
        checks++; if (fifo_count !== 5'd1) begin failures++; $display("FAIL rst_prefill: got %0d, expected 1", fifo_count); end
        rx = 1'b0;
        step(40);
        rst_n = 1'b0;
        rx = 1'b1;
        step(2);
        checks++; if (m_if.valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b, expected 0", m_if.valid); end
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL rst_mid_count: got %0d, expected 0", fifo_count); end
        rst_n = 1'b1;
        clear_counters();
        step(200);
        checks++; if (valid_rises !== 0 || fifo_count !== 5'd0) begin failures++; $display("FAIL rst_after: got %0d rises count %0d, expected 0 and 0", valid_rises, fifo_count); end
        checks++; if (ferr_cnt !== 0) begin failures++; $display("FAIL rst_after_ferr: got %0d, expected 0", ferr_cnt); end
        m_if.ready = 1'b1;
        step(2);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d;
        parity_odd = 1'b0;
        clear_counters();
        d = 8'h07;
        sb.push_back(d);
        frame_start = cyc;
        rx = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            step(16);
        end
        rx = 1'b0;
        step(16);
        rx = 1'b1;
        step(36);
        checks++; if (perr_cnt !== 1) begin failures++; $display("FAIL par_pulses: got %0d, expected 1", perr_cnt); end
        checks++; if (last_perr_cyc !== frame_start + PUSH_OFS) begin failures++; $display("FAIL par_timing: got cycle %0d, expected %0d", last_perr_cyc, frame_start + PUSH_OFS); end
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL par_sb: got %0d pending, expected 0", sb.size()); end
        parity_odd = 1'b1;
        sb.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        step(20);
        checks++; if (perr_cnt !== 1) begin failures++; $display("FAIL par_odd_ok: got %0d pulses, expected 1", perr_cnt); end
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL par_odd_sb: got %0d pending, expected 0", sb.size()); end
        parity_odd = 1'b0;
    endtask
`endif

    initial begin
        m_if.ready = 1'b1;
        clear_counters();
        test_reset();
        test_single();
        test_frame_error();
        test_overrun();
        test_full_push_pop();
        test_glitch_and_reset();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
